// File: rtl/mem_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin memory port arbiter.
// Holds the FSM encoding, the access-direction constants and the index-width helper.
package mem_arb_pkg;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} arb_state_t;

  localparam logic WR = 1'b1;
  localparam logic RD = 1'b0;

  // Width of a requester index, never below one bit.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mem_rr_arbiter_rr_picker.sv
// Combinational round-robin pick: first set request bit at or above ptr, wrapping.
// The output is valid only while found is high.
module rr_picker
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               found,
  output logic [IDX_W-1:0]   winner
);

  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[(int'(ptr) + i) % NUM_REQ]) begin
        found  = 1'b1;
        winner = IDX_W'((int'(ptr) + i) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one memory port among NUM_REQ requesters.
// One transfer at a time; a watchdog aborts transfers the memory never acknowledges.
module mem_rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int TIMEOUT    = 32
) (
  input  logic                          clk,
  input  logic                          res,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_wr_rd,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*WIDTH-1:0]      req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [WIDTH-1:0]              req_rdata,
  output logic                          req_err,
  output logic                          m_valid,
  output logic                          m_wr_rd,
  output logic [ADDR_WIDTH-1:0]         m_addr,
  output logic [WIDTH-1:0]              m_wdata,
  input  logic                          m_ready,
  input  logic [WIDTH-1:0]              m_rdata,
  output logic [$clog2(NUM_REQ)-1:0]    gnt_id,
  output logic                          busy
);

  localparam int IDX_W = idx_w(NUM_REQ);
  localparam int WD_W  = $clog2(TIMEOUT);

  if (DEPTH > (1 << ADDR_WIDTH)) begin : g_depth_chk
    $error("DEPTH does not fit in ADDR_WIDTH");
  end

  arb_state_t            state_q, state_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [IDX_W-1:0]      gnt_q, gnt_d;
  logic [WD_W-1:0]       wdog_q, wdog_d;
  logic                  m_valid_q, m_valid_d;
  logic                  m_wr_rd_q, m_wr_rd_d;
  logic [ADDR_WIDTH-1:0] m_addr_q, m_addr_d;
  logic [WIDTH-1:0]      m_wdata_q, m_wdata_d;

  logic                  pick_found;
  logic [IDX_W-1:0]      pick_id;
  logic                  done;
  logic                  tmo;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req    (req_valid),
    .ptr    (ptr_q),
    .found  (pick_found),
    .winner (pick_id)
  );

  // A real acknowledge in the watchdog's last cycle takes priority over the abort.
  assign done = (state_q == BUSY) && m_ready;
  assign tmo  = (state_q == BUSY) && !m_ready && (wdog_q == WD_W'(TIMEOUT - 1));

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    wdog_d    = wdog_q;
    m_valid_d = m_valid_q;
    m_wr_rd_d = m_wr_rd_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    req_ready = '0;
    req_rdata = '0;
    req_err   = tmo;

    if (done || tmo) req_ready[gnt_q] = 1'b1;
    if (done)        req_rdata        = m_rdata;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d   = BUSY;
          gnt_d     = pick_id;
          wdog_d    = '0;
          m_valid_d = 1'b1;
          m_wr_rd_d = req_wr_rd[pick_id] ? WR : RD;
          m_addr_d  = req_addr[pick_id*ADDR_WIDTH +: ADDR_WIDTH];
          m_wdata_d = req_wdata[pick_id*WIDTH +: WIDTH];
        end
      end
      BUSY: begin
        if (done || tmo) begin
          state_d   = IDLE;
          m_valid_d = 1'b0;
          ptr_d     = (gnt_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gnt_q     <= '0;
      wdog_q    <= '0;
      m_valid_q <= 1'b0;
      m_wr_rd_q <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      wdog_q    <= wdog_d;
      m_valid_q <= m_valid_d;
      m_wr_rd_q <= m_wr_rd_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_wr_rd = m_wr_rd_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign gnt_id  = gnt_q;
  assign busy    = (state_q == BUSY);

endmodule
